// File: rtl/sbr_pkg.sv
// Shared constants and types for the serial bus responder (sbr_frame_rx and serial_bus_responder).
package sbr_pkg;

  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam logic [7:0] CMD_RD     = 8'h02;
  localparam logic [7:0] ST_ERR     = 8'hEE;
  localparam int         RX_FRAME_W = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_WR   = 3'd2,
    S_RDW  = 3'd3,
    S_TX   = 3'd4
  } sbr_state_e;

  // Outcome of decoding a command against the buffered data bytes.
  typedef enum logic [1:0] {
    OP_ERR = 2'd0,
    OP_WR  = 2'd1,
    OP_RD  = 2'd2
  } sbr_op_e;

endpackage

// File: rtl/sbr_frame_rx.sv
// Serial frame deserializer: registers serialin once, shifts it through a 12-bit window and
// pulses frame_valid for one cycle when a complete {start, flag, byte, 00} frame is seen.
module sbr_frame_rx
  import sbr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       serialin,
  output logic       frame_valid,
  output logic       frame_flag,
  output logic [7:0] frame_byte
);

  logic                  in_q, in_d;
  logic [RX_FRAME_W-1:0] sr_q, sr_d;
  logic                  detect;

  // The first 1 after a clear is always a start bit, so it reaching the top marks a frame.
  assign detect = sr_q[RX_FRAME_W-1] & (sr_q[1:0] == 2'b00);

  always_comb begin
    in_d = serialin;
    sr_d = {sr_q[RX_FRAME_W-2:0], in_q};
    // Keep the bit arriving on the detect cycle: it may be the next frame's start bit.
    if (detect) begin
      sr_d = {{(RX_FRAME_W-1){1'b0}}, in_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
      sr_q <= '0;
    end else begin
      in_q <= in_d;
      sr_q <= sr_d;
    end
  end

  assign frame_valid = detect;
  assign frame_flag  = sr_q[RX_FRAME_W-2];
  assign frame_byte  = sr_q[RX_FRAME_W-3:2];

endmodule

// File: rtl/serial_bus_responder.sv
// Responder end of the one-wire serial register bus: buffers data bytes, runs register
// writes/reads on command frames and serializes replies. SERIAL_BUS_RESP_DEBUG_EN adds dbg.
module serial_bus_responder
  import sbr_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int TX_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serialin,
  output logic        serialout,
  output logic        wr,
  output logic [15:0] addr,
  output logic [15:0] wrdata,
  input  logic [15:0] rddata,
  output logic [15:0] rdcount,
  output logic [15:0] wrcount,
`ifdef SERIAL_BUS_RESP_DEBUG_EN
  output logic [15:0] bytecount,
  output logic [15:0] dbg
`else
  output logic [15:0] bytecount
`endif
);

  localparam int FRAME_W = 10 + TX_GAP;
  localparam int TX_W    = 3 * FRAME_W;
  localparam int CNT_W   = $clog2(TX_W + 1);
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] TX_LEN    = CNT_W'(TX_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

  function automatic logic [FRAME_W-1:0] mk_frame(input logic flag, input logic [7:0] b);
    return {1'b1, flag, b, {TX_GAP{1'b0}}};
  endfunction

  // rx_valid is a valid-only one-cycle pulse: there is no ready, every frame must be consumed.
  logic       rx_valid;
  logic       rx_flag;
  logic [7:0] rx_byte;

  sbr_frame_rx u_rx (
    .clk         (clk),
    .rst         (rst),
    .serialin    (serialin),
    .frame_valid (rx_valid),
    .frame_flag  (rx_flag),
    .frame_byte  (rx_byte)
  );

  sbr_state_e       state_q, state_d;
  sbr_op_e          op_q, op_d;
  logic [31:0]      buf_q, buf_d;
  logic [2:0]       fill_q, fill_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wrdata_q, wrdata_d;
  logic             wr_q, wr_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [TX_W-1:0]  tx_sr_q, tx_sr_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             so_q, so_d;
  logic [15:0]      rdcount_q, rdcount_d;
  logic [15:0]      wrcount_q, wrcount_d;
  logic [15:0]      bytecount_q, bytecount_d;

  logic             tx_load;
  logic [TX_W-1:0]  tx_load_bits;
  logic [CNT_W-1:0] tx_load_len;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    wr_d         = 1'b0;
    lat_d        = lat_q;
    rdcount_d    = rdcount_q;
    wrcount_d    = wrcount_q;
    bytecount_d  = bytecount_q;
    tx_load      = 1'b0;
    tx_load_bits = '0;
    tx_load_len  = FRAME_LEN;

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        case (op_q)
          OP_WR: begin
            tx_load      = 1'b1;
            tx_load_bits = {mk_frame(1'b1, CMD_WR), {(2*FRAME_W){1'b0}}};
            state_d      = S_WR;
          end
          OP_RD: begin
            lat_d   = '0;
            state_d = S_RDW;
          end
          default: begin
            tx_load      = 1'b1;
            tx_load_bits = {mk_frame(1'b1, ST_ERR), {(2*FRAME_W){1'b0}}};
            state_d      = S_TX;
          end
        endcase
      end
      S_WR: begin
        wrcount_d = wrcount_q + 16'd1;
        state_d   = S_TX;
      end
      S_RDW: begin
        if (lat_q == LAT_LAST) begin
          tx_load      = 1'b1;
          tx_load_len  = TX_LEN;
          tx_load_bits = {mk_frame(1'b0, rddata[15:8]), mk_frame(1'b0, rddata[7:0]),
                          mk_frame(1'b1, CMD_RD)};
          rdcount_d    = rdcount_q + 16'd1;
          state_d      = S_TX;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_TX: begin
        if (tx_cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame reception runs in every state; only IDLE acts on a command.
    if (rx_valid) begin
      bytecount_d = bytecount_q + 16'd1;
      if (!rx_flag) begin
        buf_d = {buf_q[23:0], rx_byte};
        if (fill_q != 3'd4) begin
          fill_d = fill_q + 3'd1;
        end
      end else begin
        buf_d  = '0;
        fill_d = '0;
        if (state_q == S_IDLE) begin
          state_d = S_EXEC;
          if (rx_byte == CMD_WR && fill_q == 3'd4) begin
            op_d     = OP_WR;
            wr_d     = 1'b1;
            addr_d   = buf_q[15:0];
            wrdata_d = buf_q[31:16];
          end else if (rx_byte == CMD_RD && fill_q >= 3'd2) begin
            op_d   = OP_RD;
            addr_d = buf_q[15:0];
          end else begin
            op_d = OP_ERR;
          end
        end
      end
    end
  end

  // Loading drives the first bit straight into serialout so the reply starts one cycle sooner.
  always_comb begin
    so_d     = 1'b0;
    tx_sr_d  = tx_sr_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_load) begin
      so_d     = tx_load_bits[TX_W-1];
      tx_sr_d  = {tx_load_bits[TX_W-2:0], 1'b0};
      tx_cnt_d = tx_load_len - CNT_ONE;
    end else if (tx_cnt_q != '0) begin
      so_d     = tx_sr_q[TX_W-1];
      tx_sr_d  = {tx_sr_q[TX_W-2:0], 1'b0};
      tx_cnt_d = tx_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ERR;
      buf_q       <= '0;
      fill_q      <= '0;
      addr_q      <= '0;
      wrdata_q    <= '0;
      wr_q        <= 1'b0;
      lat_q       <= '0;
      tx_sr_q     <= '0;
      tx_cnt_q    <= '0;
      so_q        <= 1'b0;
      rdcount_q   <= '0;
      wrcount_q   <= '0;
      bytecount_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      addr_q      <= addr_d;
      wrdata_q    <= wrdata_d;
      wr_q        <= wr_d;
      lat_q       <= lat_d;
      tx_sr_q     <= tx_sr_d;
      tx_cnt_q    <= tx_cnt_d;
      so_q        <= so_d;
      rdcount_q   <= rdcount_d;
      wrcount_q   <= wrcount_d;
      bytecount_q <= bytecount_d;
    end
  end

  assign serialout = so_q;
  assign wr        = wr_q;
  assign addr      = addr_q;
  assign wrdata    = wrdata_q;
  assign rdcount   = rdcount_q;
  assign wrcount   = wrcount_q;
  assign bytecount = bytecount_q;

`ifdef SERIAL_BUS_RESP_DEBUG_EN
  logic       cmd_dropped;
  logic [7:0] dropped_q, dropped_d;

  assign cmd_dropped = rx_valid & rx_flag & (state_q != S_IDLE);

  always_comb begin
    dropped_d = dropped_q;
    if (cmd_dropped && dropped_q != 8'hFF) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign dbg = {1'b0, state_q, dropped_q, 1'b0, fill_q};
`endif

endmodule
